pixel_tap_sampler: RTL and testbench

- Upstream front end of the frequency analysis chain.
- Consumes the raw 8-bit line-scan pixel stream and counts pixel positions within each line.
- Thresholds the pixels at three configured tap indices into 1-bit samples and publishes them once per complete line, with a one-cycle strobe, for the per-pixel frequency analyzers.
- Flags malformed lines and optionally debounces each tap across consecutive lines.

---
 rtl/pixel_tap_sampler.sv | 220 ++++++++++++++++++++++
 tb/tb_pixel_tap_sampler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_tap_sampler.sv
// pixel_tap_sampler
//   Front end of the frequency analysis chain. Counts pixel positions in a raw 8-bit line-scan
//   stream. At three tap positions it thresholds the pixel into a 1-bit sample. Once per
//   complete line it publishes the three samples together with a one-cycle strobe.
//   Malformed lines set a sticky error flag.
//
//   Optional feature, macro PIXEL_TAP_DEBOUNCE_EN:
//     Each tap output flips only after DEBOUNCE_DEPTH consecutive completed lines disagree with
//     it. When the macro is undefined, captures are published directly.
//
// Ports
//   clock          in   sampling clock, rising edge
//   reset          in   synchronous active-high reset
//   enable         in   run control; low parks the block in IDLE
//   pixel_valid    in   data carries a pixel this cycle
//   line_start     in   marks pixel 0 of a line (qualified by pixel_valid)
//   data[7:0]      in   pixel value
//   sample_data[2:0] out  bit k = published sample of tap k
//   sample_strobe  out  one-cycle pulse when sample_data updated
//   line_count[15:0] out complete lines published, wraps
//   line_error     out  sticky malformed-line flag
module pixel_tap_sampler #(
  parameter int unsigned PIXEL0_INDEX   = 63,
  parameter int unsigned PIXEL1_INDEX   = 511,
  parameter int unsigned PIXEL2_INDEX   = 1023,
  parameter int unsigned LINE_LENGTH    = 1024,
  parameter int unsigned THRESHOLD      = 128,
  parameter int unsigned DEBOUNCE_DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pixel_valid,
  input  logic        line_start,
  input  logic [7:0]  data,
  output logic [2:0]  sample_data,
  output logic        sample_strobe,
  output logic [15:0] line_count,
  output logic        line_error
);

  localparam int unsigned CntW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [CntW-1:0] LastPix = CntW'(LINE_LENGTH - 1);
  localparam logic [CntW-1:0] TapIdx [3] = '{CntW'(PIXEL0_INDEX), CntW'(PIXEL1_INDEX),
                                             CntW'(PIXEL2_INDEX)};
  // One extra bit so a threshold above 255 can never be reached.
  localparam logic [8:0] Thr = (THRESHOLD > 255) ? 9'd256 : 9'(THRESHOLD);

  typedef enum logic [1:0] {StIdle, StWaitLine, StActive} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      cap_q, cap_d;
  logic            pub_recent_q, pub_recent_d;  // a line was just published, no pixel since
  logic [2:0]      sample_d;

  logic            start_px;    // pixel accepted as pixel 0 of a new line
  logic            next_px;     // pixel accepted as continuation of the current line
  logic            short_line;
  logic            long_line;
  logic            accept;
  logic            last;
  logic            above;
  logic [CntW-1:0] pos;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM output decode: classify the current pixel.
  always_comb begin
    start_px   = 1'b0;
    next_px    = 1'b0;
    short_line = 1'b0;
    long_line  = 1'b0;
    unique case (state_q)
      StWaitLine: begin
        if (enable && pixel_valid) begin
          if (line_start) begin
            start_px = 1'b1;
          end else if (pub_recent_q) begin
            long_line = 1'b1;
          end
        end
      end
      StActive: begin
        if (enable && pixel_valid) begin
          if (line_start) begin
            short_line = 1'b1;
            start_px   = 1'b1;
          end else begin
            next_px = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign accept = start_px | next_px;
  assign pos    = start_px ? '0 : cnt_q;
  assign last   = accept && (pos == LastPix);
  assign above  = ({1'b0, data} >= Thr);

  // Next-state logic; enable low always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StWaitLine;
      end
      StWaitLine: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (start_px) begin
          state_d = last ? StWaitLine : StActive;
        end
      end
      StActive: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (last) begin
          state_d = StWaitLine;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel counter, captures and the long-line tracker.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = last ? '0 : pos + CntW'(1);
    end

    // A new line starts from clean captures so a dropped partial line cannot leak through.
    cap_d = start_px ? 3'b000 : cap_q;
    for (int k = 0; k < 3; k++) begin
      if (accept && (pos == TapIdx[k])) cap_d[k] = above;
    end
    if (!enable) cap_d = '0;

    pub_recent_d = pub_recent_q;
    if (!enable) begin
      pub_recent_d = 1'b0;
    end else if (last) begin
      pub_recent_d = 1'b1;
    end else if ((state_q == StWaitLine) && pixel_valid) begin
      pub_recent_d = 1'b0;
    end
  end

`ifdef PIXEL_TAP_DEBOUNCE_EN
  localparam logic [2:0] Depth = 3'(DEBOUNCE_DEPTH);

  logic [2:0][2:0] db_cnt_q, db_cnt_d;

  always_comb begin
    sample_d = sample_data;
    db_cnt_d = db_cnt_q;
    if (last) begin
      for (int k = 0; k < 3; k++) begin
        if (cap_d[k] != sample_data[k]) begin
          if (db_cnt_q[k] + 3'd1 == Depth) begin
            sample_d[k] = cap_d[k];
            db_cnt_d[k] = 3'd0;
          end else begin
            db_cnt_d[k] = db_cnt_q[k] + 3'd1;
          end
        end else begin
          db_cnt_d[k] = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_DEPTH;

  assign sample_d = last ? cap_d : sample_data;
`endif

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      cap_q         <= '0;
      pub_recent_q  <= 1'b0;
      sample_data   <= '0;
      sample_strobe <= 1'b0;
      line_count    <= '0;
      line_error    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      cap_q         <= cap_d;
      pub_recent_q  <= pub_recent_d;
      sample_data   <= sample_d;
      sample_strobe <= last;
      if (last) line_count <= line_count + 16'd1;
      if (short_line || long_line) line_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// Testbench for pixel_tap_sampler.
//   dut      : default parameters, scoreboarded against a line-level reference model.
//   dut_wrap : one-pixel lines, used to drive line_count through its 16-bit wrap quickly.
//   All comparisons happen in the single negedge monitor process.
module tb_pixel_tap_sampler;
  localparam int LL    = 1024;
  localparam int I0    = 63;
  localparam int I1    = 511;
  localparam int I2    = 1023;
  localparam int TH    = 128;
  localparam int DEPTH = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable, pixel_valid, line_start;
  logic [7:0]  data;
  logic [2:0]  sample_data;
  logic        sample_strobe;
  logic [15:0] line_count;
  logic        line_error;

  logic        reset_b, enable_b, valid_b, start_b;
  logic [7:0]  data_b;
  logic [2:0]  unused_sample_b;
  logic        strobe_b;
  logic [15:0] count_b;
  logic        err_b;

  pixel_tap_sampler dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .pixel_valid   (pixel_valid),
    .line_start    (line_start),
    .data          (data),
    .sample_data   (sample_data),
    .sample_strobe (sample_strobe),
    .line_count    (line_count),
    .line_error    (line_error)
  );

  pixel_tap_sampler #(
    .PIXEL0_INDEX (0),
    .PIXEL1_INDEX (0),
    .PIXEL2_INDEX (0),
    .LINE_LENGTH  (1)
  ) dut_wrap (
    .clock         (clock),
    .reset         (reset_b),
    .enable        (enable_b),
    .pixel_valid   (valid_b),
    .line_start    (start_b),
    .data          (data_b),
    .sample_data   (unused_sample_b),
    .sample_strobe (strobe_b),
    .line_count    (count_b),
    .line_error    (err_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  s;
    logic [15:0] c;
  } pub_t;
  typedef struct {
    int          kind;
    logic [15:0] v;
  } chk_t;

  pub_t exp_q[$];
  chk_t chk_q[$];

  // Reference model state.
  logic [2:0]  m_sample;
  logic [15:0] m_count;
  logic        m_err;
  int          m_run [3];
  logic [7:0]  pix [LL];

  logic b_done   = 1'b0;
  logic fin_req  = 1'b0;
  logic fin_done = 1'b0;
  int   b_seen   = 0;

  function automatic string kname(input int kind);
    case (kind)
      0:       return "sample_data";
      1:       return "sample_strobe";
      2:       return "line_count";
      default: return "line_error";
    endcase
  endfunction

  // A complete line was sent: derive the published result from the tap pixels.
  task automatic model_line();
    logic [2:0] cap;
    cap[0] = (pix[I0] >= 8'(TH));
    cap[1] = (pix[I1] >= 8'(TH));
    cap[2] = (pix[I2] >= 8'(TH));
`ifdef PIXEL_TAP_DEBOUNCE_EN
    for (int k = 0; k < 3; k++) begin
      if (cap[k] != m_sample[k]) begin
        m_run[k]++;
        if (m_run[k] == DEPTH) begin
          m_sample[k] = cap[k];
          m_run[k]    = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
`else
    m_sample = cap;
`endif
    m_count = m_count + 16'd1;
    exp_q.push_back('{s: m_sample, c: m_count});
  endtask

  task automatic model_reset();
    m_sample = '0;
    m_count  = '0;
    m_err    = 1'b0;
    for (int k = 0; k < 3; k++) m_run[k] = 0;
  endtask

  task automatic pixel(input logic ls, input logic [7:0] d);
    @(negedge clock);
    pixel_valid = 1'b1;
    line_start  = ls;
    data        = d;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clock);
      pixel_valid = 1'b0;
      line_start  = 1'($urandom);
      data        = 8'($urandom);
    end
  endtask

  task automatic send_line(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0 && $urandom_range(7) == 0) gap(1);
      pixel(i == 0, pix[i]);
    end
    if (n == LL) model_line();
  endtask

  task automatic fill_zero();
    for (int i = 0; i < LL; i++) pix[i] = 8'd0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < LL; i++) pix[i] = 8'($urandom);
    pix[I0] = 8'($urandom_range(TH + 1, TH - 2));
    pix[I1] = 8'($urandom);
  endtask

  task automatic check_all();
    gap(2);
    chk_q.push_back('{kind: 0, v: {13'd0, m_sample}});
    chk_q.push_back('{kind: 1, v: 16'd0});
    chk_q.push_back('{kind: 2, v: m_count});
    chk_q.push_back('{kind: 3, v: {15'd0, m_err}});
  endtask

  // Monitor: pops the scoreboard on every strobe and services pending state checks.
  always @(negedge clock) begin
    pub_t        e;
    chk_t        c;
    logic [15:0] act;
    if (sample_strobe) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got sample=%b count=%0d, required no strobe",
                 sample_data, line_count);
      end else begin
        e = exp_q.pop_front();
        if (sample_data !== e.s || line_count !== e.c) begin
          bad++;
          $display("FAIL publish: got sample=%b count=%0d, required sample=%b count=%0d",
                   sample_data, line_count, e.s, e.c);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        0:       act = {13'd0, sample_data};
        1:       act = {15'd0, sample_strobe};
        2:       act = line_count;
        default: act = {15'd0, line_error};
      endcase
      total++;
      if (act !== c.v) begin
        bad++;
        $display("FAIL %s: got %0h required %0h", kname(c.kind), act, c.v);
      end
    end
    if (strobe_b) begin
      b_seen++;
      if (b_seen <= 3 || b_seen >= 65534) begin
        total++;
        if (count_b !== 16'(b_seen)) begin
          bad++;
          $display("FAIL wrap_count: got %0h required %0h", count_b, 16'(b_seen));
        end
      end
    end
    if (fin_req && !fin_done) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL missing_strobe: got %0d unpublished lines, required 0", exp_q.size());
      end
      total++;
      if (b_seen != 65536) begin
        bad++;
        $display("FAIL wrap_strobes: got %0d required 65536", b_seen);
      end
      total++;
      if (count_b !== 16'h0000 || err_b !== 1'b0) begin
        bad++;
        $display("FAIL wrap_final: got count=%0h err=%b required count=0 err=0", count_b, err_b);
      end
      fin_done = 1'b1;
    end
  end

  // Wrap instance: 65536 one-pixel lines back to back.
  initial begin
    reset_b  = 1'b1;
    enable_b = 1'b0;
    valid_b  = 1'b0;
    start_b  = 1'b0;
    data_b   = 8'd0;
    repeat (2) @(negedge clock);
    reset_b  = 1'b0;
    enable_b = 1'b1;
    @(negedge clock);
    repeat (65536) begin
      @(negedge clock);
      valid_b = 1'b1;
      start_b = 1'b1;
      data_b  = 8'($urandom);
    end
    @(negedge clock);
    valid_b = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clock);
    b_done = 1'b1;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset       = 1'b1;
    enable      = 1'b0;
    pixel_valid = 1'b0;
    line_start  = 1'b0;
    data        = 8'd0;
    model_reset();
    repeat (3) @(negedge clock);
    check_all();
    reset = 1'b0;
    check_all();
    enable = 1'b1;
    gap(2);

    // Basic line: taps 0 and 2 bright.
    fill_zero();
    pix[I0] = 8'd200;
    pix[I2] = 8'd200;
    send_line(LL, 1'b0);
    check_all();

    // Threshold boundary.
    fill_zero();
    pix[I0] = 8'd127;
    pix[I1] = 8'd128;
    pix[I2] = 8'd127;
    send_line(LL, 1'b1);
    check_all();

    // Random lines, some back to back.
    for (int n = 0; n < 6; n++) begin
      fill_random();
      send_line(LL, 1'b1);
      if ($urandom_range(1) == 1) gap($urandom_range(3, 1));
    end
    check_all();

    // Long line: a non-start pixel directly after a published line.
    fill_random();
    send_line(LL, 1'b0);
    pixel(1'b0, 8'hFF);
    m_err = 1'b1;
    check_all();
    fill_random();
    send_line(LL, 1'b1);
    check_all();

    // Reset in the middle of a line.
    fill_random();
    send_line(300, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    check_all();
    reset = 1'b0;
    gap(2);

    // Enable drops at pixel 500 together with a line_start; stray pixels after re-enable.
    fill_random();
    send_line(500, 1'b0);
    @(negedge clock);
    enable      = 1'b0;
    pixel_valid = 1'b1;
    line_start  = 1'b1;
    gap(3);
    enable = 1'b1;
    gap(2);
    repeat (3) pixel(1'b0, 8'hFF);
    gap(1);
    fill_random();
    send_line(LL, 1'b0);
    check_all();

    // Short line: new line_start at pixel 700.
    fill_random();
    send_line(700, 1'b0);
    m_err = 1'b1;
    fill_random();
    send_line(LL, 1'b0);
    check_all();

    // Tap 0 pattern 1,1,0,1,1,1,0 with other taps fixed.
    for (int n = 0; n < 7; n++) begin
      fill_zero();
      pix[I1] = 8'd255;
      pix[I0] = (n == 2 || n == 6) ? 8'd10 : 8'd240;
      send_line(LL, 1'b0);
      check_all();
    end

    // Final random lines with stalls.
    for (int n = 0; n < 4; n++) begin
      fill_random();
      pix[I2] = 8'($urandom);
      send_line(LL, 1'b1);
    end
    check_all();
    gap(2);

    w = 0;
    while (!b_done && w < 80000) begin
      @(negedge clock);
      w++;
    end
    fin_req = 1'b1;
    w = 0;
    while (!fin_done && w < 10) begin
      @(negedge clock);
      w++;
    end
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
